btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Front-end stage directly upstream of the door code-lock FSM; drives that FSM's 4-bit `btn` input.
- Synchronises and debounces raw keypad buttons.
- Merges near-simultaneous presses into one code.
- Emits exactly one single-cycle code pulse per press.
- Enforces release-before-next-press, so a held key can never be read by the lock as repeated digits.

Parameters:
- NUM_BTN, 4: number of buttons; width of raw input and code output.
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised level must differ from the stable state before it is accepted (min 1).
- GATHER_CYCLES, 2: window after the first debounced press during which other presses are OR-merged into the code (min 1).
- STUCK_CYCLES, 64: cycles in HELD before stuck is flagged (used only with the optional feature).

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high; clears all state.
- btn_raw, input, NUM_BTN: asynchronous raw buttons, 1 = pressed.
- btn, output, NUM_BTN: code pulse to the lock FSM; registered; zero except during the emit cycle.
- btn_valid, output, 1: high for exactly the emit cycle.
- stuck, output, 1: stuck-key flag; tied 0 when the feature is compiled out.

Behaviour:
- Reset values: btn=0, btn_valid=0, stuck=0, sync flops=0, debounced state=0, all counters=0, FSM=IDLE.
- Per-bit synchronisation:
  - 2-flop synchroniser (s1, s2).
  - Debounced bit deb[i] and counter cnt[i], width clog2(DEBOUNCE_CYCLES+1).
  - If s2==deb[i]: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: deb[i]<=s2 and cnt<=0.
  - Else: cnt++.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is never accepted, in either direction.
- FSM states IDLE, GATHER, EMIT, HELD:
  - IDLE: if deb!=0, then acc<=deb, gcnt<=0, go to GATHER.
  - GATHER: acc<=acc|deb and gcnt++. When gcnt==GATHER_CYCLES-1: btn<=acc|deb, btn_valid<=1, go to EMIT.
  - EMIT (one cycle): btn<=0, btn_valid<=0, go to HELD.
  - HELD: no new code is emitted. Go to IDLE on the first cycle deb==0 (all buttons debounced-released). New presses during HELD are ignored and do not queue.
- Latency: number the first edge that samples btn_raw high as edge 1. btn/btn_valid become visible after edge DEBOUNCE_CYCLES+GATHER_CYCLES+3 (edge 9 with defaults).
- Merge rule: buttons that debounce within the GATHER window are OR-ed. Example: 1 and 2 → code 3. A button debouncing after the window is ignored until full release.
- Release inside GATHER: the bit stays in acc; the code is still emitted.
- Minimum spacing between two btn_valid pulses: 1 + GATHER + release debounce + the next press path. Back-to-back pulses are impossible.
- Reset asserted in any state returns all outputs to 0 immediately (asynchronous). No partial code is emitted after reset deasserts.

Optional Feature:
- Macro BTN_COND_STUCK_DETECT_EN.
- Defined:
  - A counter runs while in HELD.
  - When it reaches STUCK_CYCLES, stuck<=1.
  - stuck stays 1 until the FSM leaves HELD; it clears on the HELD→IDLE transition.
  - The counter clears on entry to HELD.
- Undefined: no counter is built; stuck is constant 0.

Decomposition:
- Package btn_cond_pkg holds:
  - state enum (IDLE, GATHER, EMIT, HELD);
  - default NUM_BTN=4;
  - localparam helper for counter widths.
- Sub-module btn_debounce holds one bit's synchroniser and debounce counter, parameterised by DEBOUNCE_CYCLES. It is instantiated NUM_BTN times via generate.
- The FSM, gather and stuck logic live in the top.

Test Plan (defaults D=4, G=2, 10 ns clock):
- Single press: btn_raw=4'b0001 held for 100 ns, then 0 → btn=1 and btn_valid=1 for exactly one cycle, after edge 9; no further pulse while held.
- Bounce: toggle btn_raw[1] at 1–3 cycle intervals for 60 ns, then hold stable → exactly one pulse btn=2. A 3-cycle glitch alone → no pulse.
- Merge: btn_raw=1, then btn_raw=3 one cycle later → one pulse btn=3. If bit 1 instead arrives 6 cycles later → pulse btn=1 only.
- Sequence: the press sequence 1, 2, 4 with full releases of 80 ns between presses → three pulses btn=1, 2, 4 in order, each one cycle wide.
- Reset mid-GATHER: assert reset 2 cycles after the press debounces → btn=0 and btn_valid=0 immediately; after release, no pulse appears.
- Stuck (feature defined, STUCK_CYCLES=64): hold btn_raw=8 for 1 µs → one pulse btn=8, then stuck=1 after 64 HELD cycles; after release, stuck=0 once debounce completes.

Source files
------------

// File: rtl/btn_cond_pkg.sv
// ---------------------------------------------------------------------------
// btn_cond_pkg
// Shared types and helpers for the keypad button conditioner.
//   state_t         : conditioner FSM states (IDLE, GATHER, EMIT, HELD)
//   DEFAULT_NUM_BTN : default keypad width
//   cntWidth()      : bit width needed for a counter that must hold 0..maxVal
// ---------------------------------------------------------------------------
package btn_cond_pkg;

    localparam int DEFAULT_NUM_BTN = 4;

    typedef enum logic [1:0] {
        IDLE,
        GATHER,
        EMIT,
        HELD
    } state_t;

    // Never returns less than 1 so degenerate parameters still give a legal vector.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// ---------------------------------------------------------------------------
// btn_conditioner_if
// Bundle between the keypad side and the conditioner.
//   btn_raw   : raw asynchronous buttons, 1 = pressed  (keypad -> conditioner)
//   btn       : one-cycle code pulse to the lock FSM   (conditioner -> lock)
//   btn_valid : high only during the code pulse        (conditioner -> lock)
//   stuck     : stuck-key flag                         (conditioner -> lock)
// Modports:
//   master : keypad/environment side, drives btn_raw
//   slave  : conditioner side, drives btn/btn_valid/stuck
// ---------------------------------------------------------------------------
interface btn_conditioner_if #(
    parameter int NUM_BTN = btn_cond_pkg::DEFAULT_NUM_BTN
) ();

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn;
    logic               btn_valid;
    logic               stuck;

    modport master (
        output btn_raw,
        input  btn,
        input  btn_valid,
        input  stuck
    );

    modport slave (
        input  btn_raw,
        output btn,
        output btn_valid,
        output stuck
    );

endinterface

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One button: 2-flop synchroniser followed by a debounce counter. The
// debounced level only changes after the synchronised level has differed
// from it for DEBOUNCE_CYCLES consecutive cycles, in either direction.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset
//   i_raw  : raw asynchronous button level
//   o_deb  : debounced level
// ---------------------------------------------------------------------------
module btn_debounce
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_deb
);

    localparam int            CW       = cntWidth(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;

    // The counter restarts whenever the synchronised level agrees with the
    // debounced one, so any run shorter than DEBOUNCE_CYCLES is discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_deb <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
// Front end for the door code-lock FSM. Synchronises and debounces the raw
// keypad, OR-merges presses that debounce within a short gather window, and
// emits exactly one single-cycle code per press. A new code is only possible
// after every button has debounced-released, so a held key never repeats.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset, clears all state and outputs
//   bus    : btn_conditioner_if.slave
//              btn_raw (in), btn (out), btn_valid (out), stuck (out)
// Optional feature macro: BTN_COND_STUCK_DETECT_EN
//   defined   : stuck rises after STUCK_CYCLES cycles in HELD and clears on
//               the HELD->IDLE transition
//   undefined : no stuck counter; stuck is constant 0
// ---------------------------------------------------------------------------
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int NUM_BTN         = DEFAULT_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GATHER_CYCLES   = 2,
    parameter int STUCK_CYCLES    = 64
) (
    input  logic               clk,
    input  logic               reset,
    btn_conditioner_if.slave   bus
);

    localparam int            GW     = cntWidth(GATHER_CYCLES);
    localparam logic [GW-1:0] G_LAST = GW'(GATHER_CYCLES - 1);

    logic [NUM_BTN-1:0] w_deb;

    state_t             r_state;
    logic [NUM_BTN-1:0] r_acc;
    logic [GW-1:0]      r_gcnt;
    logic [NUM_BTN-1:0] r_btn;
    logic               r_btnValid;

    state_t             w_stateNext;
    logic [NUM_BTN-1:0] w_accNext;
    logic [GW-1:0]      w_gcntNext;
    logic [NUM_BTN-1:0] w_btnNext;
    logic               w_btnValidNext;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .i_raw (bus.btn_raw[i]),
            .o_deb (w_deb[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_gcnt     <= '0;
            r_btn      <= '0;
            r_btnValid <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_acc      <= w_accNext;
            r_gcnt     <= w_gcntNext;
            r_btn      <= w_btnNext;
            r_btnValid <= w_btnValidNext;
        end
    end

    // btn/btn_valid default to 0 so the code is only driven for the single
    // cycle following the last GATHER cycle. HELD waits for a full release,
    // which is what stops presses arriving late from queueing a second code.
    always_comb begin
        w_stateNext    = r_state;
        w_accNext      = r_acc;
        w_gcntNext     = r_gcnt;
        w_btnNext      = '0;
        w_btnValidNext = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_deb != '0) begin
                    w_accNext   = w_deb;
                    w_gcntNext  = '0;
                    w_stateNext = GATHER;
                end
            end
            GATHER: begin
                w_accNext  = r_acc | w_deb;
                w_gcntNext = r_gcnt + GW'(1);
                if (r_gcnt == G_LAST) begin
                    w_btnNext      = r_acc | w_deb;
                    w_btnValidNext = 1'b1;
                    w_stateNext    = EMIT;
                end
            end
            EMIT: begin
                w_stateNext = HELD;
            end
            HELD: begin
                if (w_deb == '0) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign bus.btn       = r_btn;
    assign bus.btn_valid = r_btnValid;

`ifdef BTN_COND_STUCK_DETECT_EN
    localparam int            SW         = cntWidth(STUCK_CYCLES);
    localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);

    logic [SW-1:0] r_stuckCnt;
    logic          r_stuck;

    // The counter is zeroed in EMIT so it starts fresh on entry to HELD and
    // saturates once the limit is reached; stuck rises on the HELD cycle that
    // brings the count to STUCK_CYCLES and drops on the way back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stuckCnt <= '0;
            r_stuck    <= 1'b0;
        end else if (r_state == EMIT) begin
            r_stuckCnt <= '0;
            r_stuck    <= 1'b0;
        end else if (r_state == HELD) begin
            if (w_stateNext == IDLE) begin
                r_stuckCnt <= '0;
                r_stuck    <= 1'b0;
            end else if (r_stuckCnt == STUCK_LAST) begin
                r_stuck <= 1'b1;
            end else begin
                r_stuckCnt <= r_stuckCnt + SW'(1);
            end
        end else begin
            r_stuckCnt <= '0;
            r_stuck    <= 1'b0;
        end
    end

    assign bus.stuck = r_stuck;
`else
    // Evaluates to 0 for every legal STUCK_CYCLES; referencing the parameter
    // keeps it live in the build without the stuck counter.
    assign bus.stuck = (STUCK_CYCLES < 0);
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_conditioner
// Directed bench for btn_conditioner with default parameters (D=4, G=2,
// STUCK_CYCLES=64) and a 10 ns clock. Build with BTN_COND_STUCK_DETECT_EN to
// expect the stuck flag to rise during a long hold.
// ---------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int NB  = 4;
    localparam int DC  = 4;
    localparam int GC  = 2;
    localparam int SC  = 64;
    localparam int LAT = DC + GC + 3;

`ifdef BTN_COND_STUCK_DETECT_EN
    localparam logic STUCK_EXP = 1'b1;
`else
    localparam logic STUCK_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    btn_conditioner_if #(.NUM_BTN(NB)) bus ();

    btn_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DC),
        .GATHER_CYCLES   (GC),
        .STUCK_CYCLES    (SC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cycleCount = 0;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    int checkCount = 0;
    int passCount  = 0;

    logic [NB-1:0] pulseCode[$];
    int            pulseCycle[$];
    int            strayCount      = 0;
    int            backToBackCount = 0;
    logic          prevValid       = 1'b0;

    // Record every code pulse with the cycle it was seen in; flag codes
    // that appear without btn_valid and pulses wider than one cycle.
    always @(negedge clk) begin
        if (bus.btn_valid === 1'b1) begin
            pulseCode.push_back(bus.btn);
            pulseCycle.push_back(cycleCount);
        end else if (bus.btn !== '0) begin
            strayCount++;
        end
        if (bus.btn_valid === 1'b1 && prevValid === 1'b1) backToBackCount++;
        prevValid = bus.btn_valid;
    end

    initial begin
        #200us;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [NB-1:0] value, input int cycles);
        bus.btn_raw = value;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic clearPulses();
        pulseCode.delete();
        pulseCycle.delete();
    endtask

    function automatic logic [NB-1:0] getCode(input int idx);
        if (idx < pulseCode.size()) return pulseCode[idx];
        return 'x;
    endfunction

    function automatic int getCycle(input int idx);
        if (idx < pulseCycle.size()) return pulseCycle[idx];
        return -1000;
    endfunction

    int t0;

    initial begin
        reset       = 1'b1;
        bus.btn_raw = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset.btn", 32'(bus.btn), 0);
        checkOutput("reset.valid", 32'(bus.btn_valid), 0);
        checkOutput("reset.stuck", 32'(bus.stuck), 0);
        reset = 1'b0;
        applyStimulus('0, 5);

        // Single press: one pulse, code 1, LAT cycles after the press.
        clearPulses();
        t0 = cycleCount;
        applyStimulus(4'b0001, 10);
        applyStimulus(4'b0000, 20);
        checkOutput("single.count", 32'(pulseCode.size()), 1);
        checkOutput("single.code", 32'(getCode(0)), 32'h1);
        checkOutput("single.latency", 32'(getCycle(0) - t0), LAT);

        // A press lasting exactly DEBOUNCE_CYCLES is accepted.
        clearPulses();
        applyStimulus(4'b0001, 4);
        applyStimulus(4'b0000, 25);
        checkOutput("minPress.count", 32'(pulseCode.size()), 1);
        checkOutput("minPress.code", 32'(getCode(0)), 32'h1);

        // A 3-cycle glitch is rejected.
        clearPulses();
        applyStimulus(4'b0010, 3);
        applyStimulus(4'b0000, 20);
        checkOutput("glitch.count", 32'(pulseCode.size()), 0);

        // Bouncing contact then stable: one pulse, code 2.
        clearPulses();
        applyStimulus(4'b0010, 2);
        applyStimulus(4'b0000, 1);
        applyStimulus(4'b0010, 1);
        applyStimulus(4'b0000, 2);
        applyStimulus(4'b0010, 15);
        applyStimulus(4'b0000, 20);
        checkOutput("bounce.count", 32'(pulseCode.size()), 1);
        checkOutput("bounce.code", 32'(getCode(0)), 32'h2);

        // A 3-cycle release glitch while held must not produce a second code.
        clearPulses();
        applyStimulus(4'b0100, 15);
        applyStimulus(4'b0000, 3);
        applyStimulus(4'b0100, 15);
        applyStimulus(4'b0000, 20);
        checkOutput("relGlitch.count", 32'(pulseCode.size()), 1);
        checkOutput("relGlitch.code", 32'(getCode(0)), 32'h4);

        // Merge: bit 1 one cycle after bit 0.
        clearPulses();
        applyStimulus(4'b0001, 1);
        applyStimulus(4'b0011, 15);
        applyStimulus(4'b0000, 20);
        checkOutput("merge1.count", 32'(pulseCode.size()), 1);
        checkOutput("merge1.code", 32'(getCode(0)), 32'h3);

        // Merge boundary: two cycles later still lands in the window.
        clearPulses();
        applyStimulus(4'b0001, 2);
        applyStimulus(4'b0011, 15);
        applyStimulus(4'b0000, 20);
        checkOutput("merge2.code", 32'(getCode(0)), 32'h3);

        // Three cycles later misses the window.
        clearPulses();
        applyStimulus(4'b0001, 3);
        applyStimulus(4'b0011, 15);
        applyStimulus(4'b0000, 20);
        checkOutput("merge3.count", 32'(pulseCode.size()), 1);
        checkOutput("merge3.code", 32'(getCode(0)), 32'h1);

        // Six cycles later: only bit 0, late bit never queues.
        clearPulses();
        applyStimulus(4'b0001, 6);
        applyStimulus(4'b0011, 15);
        applyStimulus(4'b0000, 20);
        checkOutput("late.count", 32'(pulseCode.size()), 1);
        checkOutput("late.code", 32'(getCode(0)), 32'h1);

        // Sequence 1, 2, 4 with 80 ns releases; pulses 20 cycles apart.
        clearPulses();
        applyStimulus(4'b0001, 12);
        applyStimulus(4'b0000, 8);
        applyStimulus(4'b0010, 12);
        applyStimulus(4'b0000, 8);
        applyStimulus(4'b0100, 12);
        applyStimulus(4'b0000, 20);
        checkOutput("seq.count", 32'(pulseCode.size()), 3);
        checkOutput("seq.code0", 32'(getCode(0)), 32'h1);
        checkOutput("seq.code1", 32'(getCode(1)), 32'h2);
        checkOutput("seq.code2", 32'(getCode(2)), 32'h4);
        checkOutput("seq.gap01", 32'(getCycle(1) - getCycle(0)), 20);
        checkOutput("seq.gap12", 32'(getCycle(2) - getCycle(1)), 20);

        // Reset two cycles after the press debounces (mid-GATHER).
        clearPulses();
        applyStimulus(4'b0001, 8);
        reset       = 1'b1;
        bus.btn_raw = '0;
        #1;
        checkOutput("rstGather.btn", 32'(bus.btn), 0);
        checkOutput("rstGather.valid", 32'(bus.btn_valid), 0);
        applyStimulus(4'b0000, 3);
        reset = 1'b0;
        applyStimulus(4'b0000, 20);
        checkOutput("rstGather.count", 32'(pulseCode.size()), 0);

        // Reset during the emit cycle clears the pulse immediately.
        applyStimulus(4'b0001, LAT);
        checkOutput("rstEmit.pre", 32'(bus.btn_valid), 1);
        reset       = 1'b1;
        bus.btn_raw = '0;
        #1;
        checkOutput("rstEmit.btn", 32'(bus.btn), 0);
        checkOutput("rstEmit.valid", 32'(bus.btn_valid), 0);
        applyStimulus(4'b0000, 3);
        clearPulses();
        reset = 1'b0;
        applyStimulus(4'b0000, 20);
        checkOutput("rstEmit.count", 32'(pulseCode.size()), 0);

        // Long hold: one code 8; stuck rises only with the feature built in.
        clearPulses();
        applyStimulus(4'b1000, 40);
        checkOutput("stuck.early", 32'(bus.stuck), 0);
        applyStimulus(4'b1000, 60);
        checkOutput("stuck.held", 32'(bus.stuck), 32'(STUCK_EXP));
        checkOutput("stuck.count", 32'(pulseCode.size()), 1);
        checkOutput("stuck.code", 32'(getCode(0)), 32'h8);
        applyStimulus(4'b0000, 20);
        checkOutput("stuck.released", 32'(bus.stuck), 0);

        checkOutput("monitor.stray", 32'(strayCount), 0);
        checkOutput("monitor.backToBack", 32'(backToBackCount), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
